logic_op_unit: RTL and testbench
================================

Name: logic_op_unit

Overview:
- Parametrised, registered successor to the switch-driven 8-function gate selector.
- Applies one of 8 bitwise logic functions to WIDTH-bit operands and delivers each result through a single-entry valid/ready output register.
- Manual mode takes one operation per input handshake.
- Sweep mode steps automatically through all 8 functions, holding each for a programmable dwell time, for board LED demos.

Parameters:
WIDTH, 8, operand/result width in bits (>=1)
DWELL, 50000000, clock cycles each function is held in sweep mode (>=2)
CNT_W, $clog2(DWELL), width of dwell counter (derived; do not override)

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
a  input  WIDTH  operand A
b  input  WIDTH  operand B (ignored by BUF/NOT)
op_sel  input  3  function select, manual mode
auto_en  input  1  1 = sweep mode, 0 = manual mode
in_valid  input  1  manual-mode request valid
in_ready  output  1  manual-mode request accepted when in_valid & in_ready
result  output  WIDTH  registered function result
result_op  output  3  function code that produced result
out_valid  output  1  result/result_op valid
out_ready  input  1  downstream consumes result when out_valid & out_ready
cur_op  output  3  sweep-mode function index currently dwelling

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Function encoding, fixed, bitwise over WIDTH: 0 NAND, 1 AND, 2 NOR, 3 OR, 4 XOR, 5 XNOR, 6 BUF (a), 7 NOT (~a).
- Reset, while rst=1 at a clock edge:
  - result=0, result_op=0, out_valid=0, cur_op=0, dwell counter=0, state=MANUAL.
  - in_ready forced 0 while rst high.
  - Reset mid-transaction discards any pending result without a handshake.
- States:
  - MANUAL: entered from reset, or from SWEEP when auto_en=0.
  - SWEEP: entered from MANUAL when auto_en=1.
  - The mode change takes effect the cycle after auto_en is sampled.
  - On every entry to either state, dwell counter=0 and cur_op=0.
  - A pending out_valid result is kept across the mode change until consumed.
- Output register free condition: free = !out_valid | out_ready, so a result may be consumed and replaced in the same cycle.
- MANUAL:
  - in_ready = free (combinational; 0 in SWEEP).
  - On accept, next edge: result=f(op_sel,a,b), result_op=op_sel, out_valid=1.
  - Latency 1 cycle; throughput 1 per cycle with out_ready held 1.
  - op_sel, a and b are sampled only on accept.
- SWEEP:
  - in_valid is ignored.
  - Dwell counter increments each cycle while counter < DWELL-1.
  - At counter = DWELL-1 and free=1:
    - load result=f(cur_op,a,b), result_op=cur_op, out_valid=1;
    - cur_op increments, wrapping 7->0;
    - counter resets to 0.
  - At counter = DWELL-1 and free=0: counter and cur_op hold (stall) until free.
- Output hold: out_valid stays 1 and result/result_op stay stable until out_ready=1. Otherwise out_valid clears the edge after consumption if no new load occurs.
- Width: all functions are pure bitwise. No carries, no sign, and no truncation for any WIDTH.

Test Plan:
- Reset: WIDTH=8, DWELL=4. Hold rst 2 cycles with in_valid=1 -> out_valid=0, result=8'h00, cur_op=0, in_ready=0. Release -> in_ready=1.
- Manual all ops: a=8'hC5, b=8'hA3, op_sel 0..7 back-to-back with out_ready=1. Required results, one per cycle at 1-cycle latency: 7E, 81, 18, E7, 66, 99, C5, 3A; result_op matching.
- Back-pressure: out_ready=0 after op 4 accepted -> in_ready=0, result holds 8'h66 for 5 cycles. Raise out_ready with in_valid, op 1 -> same-cycle consume+accept, next result 8'h81.
- Sweep: auto_en=1, a=8'hF0, b=8'h0F, out_ready=1.
  - out_valid pulses every 4 cycles.
  - result sequence FF, 00, 00, FF, FF, 00, F0, 0F with result_op 0..7, then wraps to op 0.
- Sweep stall: out_ready=0 for 10 cycles at dwell end -> cur_op frozen, single pending result held. Release -> sweep resumes with next op, no op skipped.
- Mode switch mid-dwell: auto_en 1->0 at counter=2 -> cur_op=0 next cycle, in_ready=1, pending result preserved. Then rst mid-transaction -> out_valid=0 next edge.

Source files
------------

// File: rtl/logic_op_unit.sv
// logic_op_unit: eight bitwise gate functions on WIDTH-bit operands, with a
// single-entry valid/ready result register. Manual mode runs one operation per
// input handshake. Sweep mode cycles through all eight functions, holding each
// for DWELL cycles, which is intended for LED demos on a board.
//
//   state  | meaning
//   MANUAL | one operation per in_valid/in_ready handshake
//   SWEEP  | auto-step through ops 0..7, one result per dwell period
//
// Function codes: 0 NAND, 1 AND, 2 NOR, 3 OR, 4 XOR, 5 XNOR, 6 BUF a, 7 NOT a
module logic_op_unit #(
  parameter int WIDTH = 8,
  parameter int DWELL = 50000000,
  parameter int CNT_W = $clog2(DWELL)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op_sel,
  input  logic             auto_en,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] result,
  output logic [2:0]       result_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       cur_op
);

  typedef enum logic {
    MANUAL = 1'b0,
    SWEEP  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       cur_op_nxt;
  logic [WIDTH-1:0] result_nxt;
  logic [2:0]       result_op_nxt;
  logic             out_valid_nxt;
  logic             free;

  function automatic logic [WIDTH-1:0] apply_op(input logic [2:0]       op,
                                                input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] r;
    case (op)
      3'd0:    r = ~(x & y);
      3'd1:    r = x & y;
      3'd2:    r = ~(x | y);
      3'd3:    r = x | y;
      3'd4:    r = x ^ y;
      3'd5:    r = ~(x ^ y);
      3'd6:    r = x;
      default: r = ~x;
    endcase
    return r;
  endfunction

  // A result can be replaced in the same cycle it is consumed.
  assign free = ~out_valid | out_ready;

  // Next-state, dwell timing, output-register load and handshake.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    cur_op_nxt    = cur_op;
    result_nxt    = result;
    result_op_nxt = result_op;
    out_valid_nxt = out_valid & ~out_ready;
    in_ready      = 1'b0;
    case (state)
      MANUAL: begin
        in_ready = free & ~rst;
        if (in_valid && free) begin
          result_nxt    = apply_op(op_sel, a, b);
          result_op_nxt = op_sel;
          out_valid_nxt = 1'b1;
        end
        if (auto_en) begin
          state_nxt  = SWEEP;
          cnt_nxt    = '0;
          cur_op_nxt = 3'd0;
        end
      end
      SWEEP: begin
        if (!auto_en) begin
          state_nxt  = MANUAL;
          cnt_nxt    = '0;
          cur_op_nxt = 3'd0;
        end else if (cnt == CNT_LAST) begin
          // Stall at dwell end until the output register can take the result.
          if (free) begin
            result_nxt    = apply_op(cur_op, a, b);
            result_op_nxt = cur_op;
            out_valid_nxt = 1'b1;
            cur_op_nxt    = cur_op + 3'd1;
            cnt_nxt       = '0;
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: state_nxt = MANUAL;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= MANUAL;
      cnt       <= '0;
      cur_op    <= 3'd0;
      result    <= '0;
      result_op <= 3'd0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      cur_op    <= cur_op_nxt;
      result    <= result_nxt;
      result_op <= result_op_nxt;
      out_valid <= out_valid_nxt;
    end
  end

endmodule

// File: tb/tb_logic_op_unit.sv
// Bench for logic_op_unit: directed stimulus, a per-bit truth-table model
// checked every cycle, and literal expectations at key points.
module tb_logic_op_unit;

  localparam int WIDTH = 8;
  localparam int DWELL = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic [2:0] op_sel = 3'd0;
  logic       auto_en = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b1;
  logic       in_ready;
  logic [7:0] result;
  logic [2:0] result_op;
  logic       out_valid;
  logic [2:0] cur_op;

  int n_pass = 0;
  int n_total = 0;
  bit chk_en = 1'b0;

  // Truth table per op, indexed by {a_bit, b_bit}.
  logic [3:0] tt [8] = '{4'b0111, 4'b1000, 4'b0001, 4'b1110,
                         4'b0110, 4'b1001, 4'b1100, 4'b0011};
  logic [7:0] man_exp [8] = '{8'h7E, 8'h81, 8'h18, 8'hE7, 8'h66, 8'h99, 8'hC5, 8'h3A};
  logic [7:0] swp_exp [8] = '{8'hFF, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'hF0, 8'h0F};

  // Model state
  bit         m_sweep;
  int         m_cnt;
  int         m_idx;
  bit         m_valid;
  logic [7:0] m_res;
  int         m_rop;

  logic_op_unit #(.WIDTH(WIDTH), .DWELL(DWELL)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .op_sel(op_sel), .auto_en(auto_en),
    .in_valid(in_valid), .in_ready(in_ready), .result(result),
    .result_op(result_op), .out_valid(out_valid), .out_ready(out_ready),
    .cur_op(cur_op)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] model_f(input int op, input logic [7:0] x, input logic [7:0] y);
    logic [7:0] r;
    logic [3:0] t;
    t = tt[op];
    for (int i = 0; i < 8; i++) r[i] = t[{x[i], y[i]}];
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h required %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare DUT with model, then advance the model by one clock.
  always @(negedge clk) begin
    bit         free;
    bit         load;
    logic [7:0] l_res;
    int         l_op;
    free = !m_valid || out_ready;
    if (chk_en) begin
      chk("m_out_valid", 32'(out_valid), 32'(m_valid));
      if (m_valid) begin
        chk("m_result", 32'(result), 32'(m_res));
        chk("m_result_op", 32'(result_op), 32'(m_rop));
      end
      chk("m_cur_op", 32'(cur_op), 32'(m_idx));
      chk("m_in_ready", 32'(in_ready), 32'(!rst && !m_sweep && free));
    end
    if (rst) begin
      m_sweep = 0; m_cnt = 0; m_idx = 0; m_valid = 0; m_res = 8'h00; m_rop = 0;
    end else begin
      load = 0; l_res = 8'h00; l_op = 0;
      if (!m_sweep) begin
        if (in_valid && free) begin
          load = 1; l_op = int'(op_sel); l_res = model_f(l_op, a, b);
        end
        if (auto_en) begin m_sweep = 1; m_cnt = 0; m_idx = 0; end
      end else if (!auto_en) begin
        m_sweep = 0; m_cnt = 0; m_idx = 0;
      end else if (m_cnt == DWELL - 1) begin
        if (free) begin
          load = 1; l_op = m_idx; l_res = model_f(m_idx, a, b);
          m_idx = (m_idx + 1) % 8; m_cnt = 0;
        end
      end else begin
        m_cnt++;
      end
      if (load) begin m_valid = 1; m_res = l_res; m_rop = l_op; end
      else if (out_ready) m_valid = 0;
    end
  end

  initial begin
    // Reset with in_valid asserted
    rst = 1; in_valid = 1; a = 8'hC5; b = 8'hA3; out_ready = 1;
    tick();
    chk_en = 1;
    tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", 32'(result), 32'h00);
    chk("rst_cur_op", 32'(cur_op), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    rst = 0; in_valid = 0;
    #1;
    chk("rel_in_ready", 32'(in_ready), 32'd1);

    // Manual mode, all ops back-to-back
    for (int k = 0; k < 8; k++) begin
      op_sel = 3'(k); in_valid = 1;
      tick();
      chk("man_result", 32'(result), 32'(man_exp[k]));
      chk("man_result_op", 32'(result_op), 32'(k));
      chk("man_out_valid", 32'(out_valid), 32'd1);
    end

    // Back-pressure
    op_sel = 3'd4;
    tick();
    chk("bp_load", 32'(result), 32'h66);
    out_ready = 0; op_sel = 3'd1;
    #1;
    chk("bp_in_ready_lo", 32'(in_ready), 32'd0);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_hold", 32'(result), 32'h66);
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1;
    #1;
    chk("bp_in_ready_hi", 32'(in_ready), 32'd1);
    tick();
    chk("bp_next", 32'(result), 32'h81);
    chk("bp_next_op", 32'(result_op), 32'd1);
    in_valid = 0;

    // Sweep mode
    a = 8'hF0; b = 8'h0F; auto_en = 1; out_ready = 1;
    repeat (5) tick();
    chk("swp_valid", 32'(out_valid), 32'd1);
    chk("swp_result", 32'(result), 32'(swp_exp[0]));
    chk("swp_op", 32'(result_op), 32'd0);
    for (int k = 1; k <= 8; k++) begin
      repeat (3) tick();
      chk("swp_gap", 32'(out_valid), 32'd0);
      tick();
      chk("swp_valid", 32'(out_valid), 32'd1);
      chk("swp_result", 32'(result), 32'(swp_exp[k % 8]));
      chk("swp_op", 32'(result_op), 32'(k % 8));
    end

    // Sweep stall at dwell end
    out_ready = 0;
    for (int k = 0; k < 13; k++) begin
      tick();
      chk("stall_result", 32'(result), 32'hFF);
      chk("stall_op", 32'(result_op), 32'd0);
      chk("stall_cur_op", 32'(cur_op), 32'd1);
    end
    out_ready = 1;
    tick();
    chk("resume_op", 32'(result_op), 32'd1);
    chk("resume_result", 32'(result), 32'h00);
    chk("resume_cur_op", 32'(cur_op), 32'd2);
    repeat (4) tick();
    chk("resume_op2", 32'(result_op), 32'd2);
    chk("resume_cur_op2", 32'(cur_op), 32'd3);

    // Mode switch mid-dwell with a pending result
    out_ready = 0;
    tick();
    tick();
    auto_en = 0;
    tick();
    chk("sw_cur_op", 32'(cur_op), 32'd0);
    chk("sw_pending_valid", 32'(out_valid), 32'd1);
    chk("sw_pending_op", 32'(result_op), 32'd2);
    a = 8'hC5; b = 8'hA3; op_sel = 3'd5; in_valid = 1; out_ready = 1;
    #1;
    chk("sw_in_ready", 32'(in_ready), 32'd1);
    tick();
    chk("sw_man_result", 32'(result), 32'h99);
    chk("sw_man_op", 32'(result_op), 32'd5);

    // Reset mid-transaction
    op_sel = 3'd0; out_ready = 0; rst = 1;
    tick();
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    rst = 0; in_valid = 0;
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
